// File: rtl/rps_pkg.sv
// rps_pkg: shared choice/winner codes and round-controller state encoding.
package rps_pkg;

    localparam logic [1:0] ROCK        = 2'd0;
    localparam logic [1:0] PAPER       = 2'd1;
    localparam logic [1:0] SCISSORS    = 2'd2;
    localparam logic [1:0] SEL_INVALID = 2'd3;

    localparam logic [1:0] W_NONE = 2'd0;
    localparam logic [1:0] W_P1   = 2'd1;
    localparam logic [1:0] W_P2   = 2'd2;
    localparam logic [1:0] W_TIE  = 2'd3;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        COUNT = 2'd1,
        SHOW  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rps_judge.sv
// rps_judge: decides a round from two valid choices via (a - b) mod 3.
module rps_judge
    import rps_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [1:0] w
);

    logic [2:0] diff;
    logic [2:0] d;

    // Bias by 3 so the subtraction never wraps for choices 0..2
    assign diff = {1'b0, a} + 3'd3 - {1'b0, b};
    assign d    = (diff >= 3'd3) ? diff - 3'd3 : diff;
    assign w    = (d == 3'd0) ? W_TIE : (d == 3'd1) ? W_P1 : W_P2;

endmodule

// File: rtl/rps_round_ctrl.sv
// rps_round_ctrl: latches player choices, delays the reveal, judges rounds
// and keeps match scores for the seven-segment display path.
module rps_round_ctrl
    import rps_pkg::*;
#(
    parameter int REVEAL_DLY = 4,
    parameter int WIN_SCORE  = 3,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         p1_sel,
    input  logic               p1_lock,
    input  logic [1:0]         p2_sel,
    input  logic               p2_lock,
    input  logic               new_round,
    output logic [3:0]         p1_choice,
    output logic [3:0]         p2_choice,
    output logic               reveal,
    output logic               p1_locked,
    output logic               p2_locked,
    output logic [1:0]         winner,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               match_over
);

    localparam int CW = $clog2(REVEAL_DLY + 1);
    localparam logic [CW-1:0]      CNT_LOAD = CW'(REVEAL_DLY - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    state_t        state;
    logic [1:0]    p1_q, p2_q;
    logic [CW-1:0] cnt;
    logic [1:0]    judged;
    logic          p1_acc, p2_acc;

    assign p1_acc = p1_lock && (p1_sel != SEL_INVALID) && !p1_locked;
    assign p2_acc = p2_lock && (p2_sel != SEL_INVALID) && !p2_locked;

    rps_judge u_judge (.a(p1_q), .b(p2_q), .w(judged));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT;
            p1_q       <= ROCK;
            p2_q       <= ROCK;
            cnt        <= '0;
            p1_choice  <= '0;
            p2_choice  <= '0;
            reveal     <= 1'b0;
            p1_locked  <= 1'b0;
            p2_locked  <= 1'b0;
            winner     <= W_NONE;
            p1_score   <= '0;
            p2_score   <= '0;
            match_over <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (p1_acc) begin
                        p1_q      <= p1_sel;
                        p1_locked <= 1'b1;
                    end
                    if (p2_acc) begin
                        p2_q      <= p2_sel;
                        p2_locked <= 1'b1;
                    end
                    // Counting starts alongside the second flag so reveal lands REVEAL_DLY later
                    if ((p1_locked || p1_acc) && (p2_locked || p2_acc)) begin
                        state <= COUNT;
                        cnt   <= CNT_LOAD;
                    end
                end
                COUNT: begin
                    if (cnt == '0) begin
                        state     <= SHOW;
                        reveal    <= 1'b1;
                        winner    <= judged;
                        p1_choice <= {2'b00, p1_q};
                        p2_choice <= {2'b00, p2_q};
                        if (judged == W_P1 && p1_score < WIN)
                            p1_score <= p1_score + 1'b1;
                        if (judged == W_P2 && p2_score < WIN)
                            p2_score <= p2_score + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHOW: begin
                    if (p1_score == WIN || p2_score == WIN) begin
                        state      <= DONE;
                        match_over <= 1'b1;
                    end else if (new_round) begin
                        state     <= WAIT;
                        reveal    <= 1'b0;
                        winner    <= W_NONE;
                        p1_choice <= '0;
                        p2_choice <= '0;
                        p1_locked <= 1'b0;
                        p2_locked <= 1'b0;
                    end
                end
                DONE: begin
                    if (new_round) begin
                        state      <= WAIT;
                        reveal     <= 1'b0;
                        winner     <= W_NONE;
                        p1_choice  <= '0;
                        p2_choice  <= '0;
                        p1_locked  <= 1'b0;
                        p2_locked  <= 1'b0;
                        p1_score   <= '0;
                        p2_score   <= '0;
                        match_over <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rps_round_ctrl.sv
// tb_rps_round_ctrl: directed plus randomized rounds against a rule-level model.
module tb_rps_round_ctrl;

    localparam int REVEAL_DLY = 4;
    localparam int WIN_SCORE  = 3;
    localparam int SCORE_W    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] p1_sel = '0, p2_sel = '0;
    logic p1_lock = 1'b0, p2_lock = 1'b0, new_round = 1'b0;
    logic [3:0] p1_choice, p2_choice;
    logic reveal, p1_locked, p2_locked, match_over;
    logic [1:0] winner;
    logic [SCORE_W-1:0] p1_score, p2_score;
    logic [1:0] ja = '0, jb = '0, jw;

    int checks = 0;
    int failures = 0;
    bit l1, l2;
    logic [1:0] e1, e2;
    int s1, s2;

    always #5 clk = ~clk;

    rps_round_ctrl #(.REVEAL_DLY(REVEAL_DLY), .WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .p1_sel(p1_sel), .p1_lock(p1_lock), .p2_sel(p2_sel), .p2_lock(p2_lock),
        .new_round(new_round),
        .p1_choice(p1_choice), .p2_choice(p2_choice), .reveal(reveal),
        .p1_locked(p1_locked), .p2_locked(p2_locked), .winner(winner),
        .p1_score(p1_score), .p2_score(p2_score), .match_over(match_over)
    );

    rps_judge u_judge (.a(ja), .b(jb), .w(jw));

    function automatic logic [1:0] ref_win(input logic [1:0] a, input logic [1:0] b);
        if (a == b) return 2'd3;
        if ((a == 2'd0 && b == 2'd2) || (a == 2'd1 && b == 2'd0) || (a == 2'd2 && b == 2'd1))
            return 2'd1;
        return 2'd2;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        l1 = 0; l2 = 0; s1 = 0; s2 = 0;
    endtask

    task automatic drive_noise(input bit nr);
        p1_lock = $urandom_range(0, 1) == 1;
        p2_lock = $urandom_range(0, 1) == 1;
        p1_sel = 2'($urandom_range(0, 3));
        p2_sel = 2'($urandom_range(0, 3));
        new_round = nr;
    endtask

    task automatic clear_in;
        p1_lock = 0; p2_lock = 0; new_round = 0;
    endtask

    task automatic try_lock(input bit a, input logic [1:0] sa, input bit b, input logic [1:0] sb, input bit nr);
        p1_lock = a; p1_sel = sa; p2_lock = b; p2_sel = sb; new_round = nr;
        tick;
        clear_in;
        if (a && sa != 2'd3 && !l1) begin l1 = 1; e1 = sa; end
        if (b && sb != 2'd3 && !l2) begin l2 = 1; e2 = sb; end
        check("p1_locked", 32'(p1_locked), 32'(l1));
        check("p2_locked", 32'(p2_locked), 32'(l2));
        check("reveal_wait", 32'(reveal), 0);
    endtask

    task automatic finish_round;
        int n;
        logic [1:0] w;
        n = 0;
        while (!reveal && n < REVEAL_DLY + 3) begin
            drive_noise($urandom_range(0, 1) == 1);
            tick;
            clear_in;
            n++;
        end
        check("reveal_delay", 32'(n), 32'(REVEAL_DLY));
        w = ref_win(e1, e2);
        if (w == 2'd1 && s1 < WIN_SCORE) s1++;
        if (w == 2'd2 && s2 < WIN_SCORE) s2++;
        check("p1_choice", 32'(p1_choice), 32'({2'b00, e1}));
        check("p2_choice", 32'(p2_choice), 32'({2'b00, e2}));
        check("winner", 32'(winner), 32'(w));
        check("p1_score", 32'(p1_score), 32'(s1));
        check("p2_score", 32'(p2_score), 32'(s2));
        check("match_over_show", 32'(match_over), 0);
        drive_noise(0);
        tick;
        clear_in;
        check("reveal_hold", 32'(reveal), 1);
        check("winner_hold", 32'(winner), 32'(w));
        if (s1 == WIN_SCORE || s2 == WIN_SCORE) begin
            check("match_over", 32'(match_over), 1);
            drive_noise(0);
            tick;
            clear_in;
            check("done_p1_score", 32'(p1_score), 32'(s1));
            check("done_p2_score", 32'(p2_score), 32'(s2));
            check("done_choice", 32'(p1_choice), 32'({2'b00, e1}));
            drive_noise(1);
            tick;
            clear_in;
            s1 = 0; s2 = 0;
            check("restart_match_over", 32'(match_over), 0);
            check("restart_scores", 32'({p1_score, p2_score}), 0);
        end else begin
            check("match_over_hold", 32'(match_over), 0);
            drive_noise(1);
            tick;
            clear_in;
            check("nr_scores", 32'({p1_score, p2_score}), 32'({4'(s1), 4'(s2)}));
        end
        l1 = 0; l2 = 0;
        check("nr_reveal", 32'(reveal), 0);
        check("nr_winner", 32'(winner), 0);
        check("nr_choices", 32'({p1_choice, p2_choice}), 0);
        check("nr_locked", 32'({p1_locked, p2_locked}), 0);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                ja = 2'(i); jb = 2'(j);
                #1;
                check("judge", 32'(jw), 32'(ref_win(2'(i), 2'(j))));
            end
        repeat (3) tick;
        check("rst_outputs", 32'({p1_choice, p2_choice, reveal, p1_locked, p2_locked, winner, match_over}), 0);
        check("rst_scores", 32'({p1_score, p2_score}), 0);
        rst_n = 1;
        tick;

        // paper vs rock in separate cycles
        try_lock(1, 2'd1, 0, 2'd0, 0);
        try_lock(0, 2'd0, 0, 2'd0, 1);
        try_lock(0, 2'd0, 1, 2'd0, 0);
        finish_round();
        // simultaneous rock vs scissors
        try_lock(1, 2'd0, 1, 2'd2, 0);
        finish_round();
        // tie on scissors
        try_lock(1, 2'd2, 1, 2'd2, 0);
        finish_round();
        // invalid, then rock, then ignored paper; p1 reaches the target here
        try_lock(1, 2'd3, 0, 2'd0, 0);
        try_lock(1, 2'd0, 0, 2'd0, 0);
        try_lock(1, 2'd1, 1, 2'd3, 0);
        try_lock(1, 2'd1, 1, 2'd2, 0);
        finish_round();
        // player 2 takes three straight rounds
        repeat (3) begin
            try_lock(1, 2'd0, 1, 2'd1, 0);
            finish_round();
        end
        // disturbance and reset during COUNT
        try_lock(1, 2'd2, 1, 2'd1, 0);
        repeat (2) begin
            drive_noise(1);
            tick;
            clear_in;
            check("count_reveal", 32'(reveal), 0);
            check("count_locked", 32'({p1_locked, p2_locked}), 3);
        end
        rst_n = 0;
        #1;
        check("midrst_outputs", 32'({p1_choice, p2_choice, reveal, p1_locked, p2_locked, winner, match_over}), 0);
        check("midrst_scores", 32'({p1_score, p2_score}), 0);
        tick;
        rst_n = 1;
        model_reset();
        tick;
        check("post_rst_locked", 32'({p1_locked, p2_locked}), 0);

        repeat (40) begin
            int k;
            k = 0;
            while (!(l1 && l2) && k < 100) begin
                try_lock($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                         $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                         $urandom_range(0, 3) == 0);
                k++;
            end
            check("lock_timeout", 32'(l1 && l2), 1);
            finish_round();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
